prime_sieve_ctrl: RTL and testbench
===================================

Name: prime_sieve_ctrl

Overview:
- Sequences the 1-bit dual-port sieve RAM (port A write, port B read, 20-bit address) through clear, Eratosthenes marking and prime lookup.
- After the sieve completes, serves "next prime" queries, typically issued on the one-second tick, to the display path.
- It is the only master of the RAM. All RAM traffic is sequenced by this FSM.

Parameters:
- N, 1000000, sieve size; covers addresses 0..N-1; requires 4 <= N <= 2**AW.
- AW, 20, RAM address width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a full sieve run
- busy  out  1  high while CLEAR/OUTER/MARK run
- done  out  1  high in READY/SCAN; sieve contents valid
- ram_we  out  1  port A write enable
- ram_waddr  out  AW  port A address
- ram_wdata  out  1  port A data
- ram_raddr  out  AW  port B address
- ram_rdata  in  1  port B data; registered read, valid the cycle after ram_raddr is sampled
- nxt_req  in  1  request next prime; level, sampled only in READY
- nxt_ack  out  1  one-cycle pulse; nxt_prime/nxt_wrap valid
- nxt_prime  out  AW  returned prime; holds value until next ack
- nxt_wrap  out  1  set with ack when the scan wrapped past N-1

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values: state=IDLE; every output = 0. Cursor = 1, i = 2, j = 0.
- Reset mid-operation aborts immediately, with ram_we=0 from reset assertion. RAM contents are undefined after that, and done stays 0 until a new full run.
- IDLE: on start go to CLEAR; busy=1, done=0.
- CLEAR: one write per cycle, addr k = 0..N-1; wdata = 0 for k<2, else 1. This takes exactly N cycles with ram_we=1. Then i=2 and go to OUTER_RD.
- OUTER_RD: if i*i >= N (product computed at 2*AW bits), go to READY with busy=0, done=1 and cursor=1. Otherwise drive ram_raddr=i and go to OUTER_WAIT.
- OUTER_WAIT: sample ram_rdata.
  - If 1: j=i*i, go to MARK.
  - If 0: i=i+1, go to OUTER_RD.
- MARK: each cycle, if j < N, write 0 at j (ram_we=1) and set j=j+i. j is AW+1 bits wide, so no wrap is possible. If j >= N, ram_we=0, i=i+1, go to OUTER_RD.
- Read-after-write: a MARK write always completes at least 1 cycle before the next OUTER_RD read. No bypass is needed.
- READY: done=1.
  - On nxt_req=1: a=cursor+1; if a >= N then a=2 and set the wrap flag. Go to SCAN_RD.
  - On start: restart at CLEAR (done=0).
  - start has priority over nxt_req.
- SCAN_RD: ram_raddr=a, go to SCAN_WAIT.
- SCAN_WAIT:
  - If ram_rdata=1: nxt_prime=a, cursor=a, nxt_wrap=wrap flag, nxt_ack=1 for one cycle, clear wrap flag, return to READY.
  - Otherwise: a=a+1. If a >= N then a=2 and set the wrap flag. Go to SCAN_RD.
  - Each address costs 2 cycles. Termination is guaranteed because 2 is prime.
- start outside IDLE/READY is ignored. nxt_req outside READY is ignored, and no ack is produced for it.
- nxt_req held high: the next scan begins in the cycle after the ack, giving back-to-back primes.
- ram_we=0 in every state except CLEAR and MARK. ram_raddr holds its last value when no read is in progress.

Test Plan:
- N=30, behavioural 1-cycle RAM; reset, start pulse -> ram_we high for exactly 30 consecutive cycles in CLEAR. Final RAM = 1 at {2,3,5,7,11,13,17,19,23,29}, 0 elsewhere. busy falls and done rises in the same cycle. Only i=2,3,5 enter MARK.
- N=30 after done: hold nxt_req high for 11 acks -> nxt_prime = 2,3,5,7,11,13,17,19,23,29,2. nxt_wrap=1 only on the 11th ack.
- Single query latency: N=30, cursor=23, one nxt_req -> scan reads 24..29 (6 addresses), ack with 29 exactly 13 cycles after req.
- Boundary N=4: sieve marks only 0,1 (i=2: 4>=4, so no MARK). Queries return 2,3, then 2 with wrap=1.
- Reset mid-MARK (N=1000, assert rstn low during i=3 marking) -> all outputs 0 at once, including ram_we. Re-start -> full correct sieve; 168 primes counted by repeated queries before the first wrap.
- start during busy ignored; start in READY with nxt_req also high -> CLEAR re-entered, no nxt_ack emitted, done drops next cycle.

Source files
------------

// File: rtl/prime_sieve_ctrl.sv
// prime_sieve_ctrl: drives a 1-bit sieve RAM through clear, Eratosthenes marking
// and next-prime lookup; sole master of both RAM ports.
module prime_sieve_ctrl #(
    parameter int N  = 1000000,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic          ram_rdata,
    input  logic          nxt_req,
    output logic          nxt_ack,
    output logic [AW-1:0] nxt_prime,
    output logic          nxt_wrap
);
    localparam logic [AW:0]     NL = (AW+1)'(N);
    localparam logic [2*AW-1:0] NW = (2*AW)'(N);

    typedef enum logic [2:0] {
        IDLE, CLEAR, OUTER_RD, OUTER_WAIT, MARK, READY, SCAN_RD, SCAN_WAIT
    } state_t;

    state_t          state;
    logic [AW-1:0]   i, cursor, a;
    logic [AW:0]     j;
    logic            wrap;
    logic [2*AW-1:0] i_sq;
    logic [AW-1:0]   i_nx, a_nx, c_nx;
    logic [AW:0]     a_inc, c_inc;
    logic            a_wr, c_wr;

    assign i_sq  = (2*AW)'(i) * (2*AW)'(i);
    assign i_nx  = i + AW'(1);
    assign a_inc = {1'b0, a} + (AW+1)'(1);
    assign c_inc = {1'b0, cursor} + (AW+1)'(1);
    assign a_wr  = a_inc >= NL;
    assign c_wr  = c_inc >= NL;
    assign a_nx  = a_wr ? AW'(2) : a_inc[AW-1:0];
    assign c_nx  = c_wr ? AW'(2) : c_inc[AW-1:0];

    // Read addresses are loaded on entry to *_RD so the registered RAM output
    // is ready to sample in the matching *_WAIT state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= 1'b0;
            ram_raddr <= '0;
            nxt_ack   <= 1'b0;
            nxt_prime <= '0;
            nxt_wrap  <= 1'b0;
            i         <= AW'(2);
            j         <= '0;
            cursor    <= AW'(1);
            a         <= '0;
            wrap      <= 1'b0;
        end else begin
            nxt_ack <= 1'b0;
            if (start && (state == IDLE || state == READY)) begin
                state     <= CLEAR;
                busy      <= 1'b1;
                done      <= 1'b0;
                ram_we    <= 1'b1;
                ram_waddr <= '0;
                ram_wdata <= 1'b0;
            end else begin
                case (state)
                    CLEAR: begin
                        if ({1'b0, ram_waddr} == NL - (AW+1)'(1)) begin
                            ram_we    <= 1'b0;
                            i         <= AW'(2);
                            ram_raddr <= AW'(2);
                            state     <= OUTER_RD;
                        end else begin
                            ram_waddr <= ram_waddr + AW'(1);
                            ram_wdata <= ram_waddr != '0;
                        end
                    end
                    OUTER_RD: begin
                        if (i_sq >= NW) begin
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            cursor <= AW'(1);
                            state  <= READY;
                        end else begin
                            state <= OUTER_WAIT;
                        end
                    end
                    OUTER_WAIT: begin
                        if (ram_rdata) begin
                            j     <= i_sq[AW:0];
                            state <= MARK;
                        end else begin
                            i         <= i_nx;
                            ram_raddr <= i_nx;
                            state     <= OUTER_RD;
                        end
                    end
                    MARK: begin
                        if (j < NL) begin
                            ram_we    <= 1'b1;
                            ram_waddr <= j[AW-1:0];
                            ram_wdata <= 1'b0;
                            j         <= j + {1'b0, i};
                        end else begin
                            ram_we    <= 1'b0;
                            i         <= i_nx;
                            ram_raddr <= i_nx;
                            state     <= OUTER_RD;
                        end
                    end
                    READY: begin
                        if (nxt_req) begin
                            a         <= c_nx;
                            ram_raddr <= c_nx;
                            wrap      <= c_wr;
                            state     <= SCAN_RD;
                        end
                    end
                    SCAN_RD: state <= SCAN_WAIT;
                    SCAN_WAIT: begin
                        if (ram_rdata) begin
                            nxt_prime <= a;
                            cursor    <= a;
                            nxt_wrap  <= wrap;
                            nxt_ack   <= 1'b1;
                            wrap      <= 1'b0;
                            state     <= READY;
                        end else begin
                            a         <= a_nx;
                            ram_raddr <= a_nx;
                            wrap      <= wrap | a_wr;
                            state     <= SCAN_RD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prime_sieve_ctrl.sv
// tb_prime_sieve_ctrl: three sieve controllers (N=30, 4, 1000) on behavioural RAMs;
// expected acks are queued by the stimulus and popped by an ack monitor.
module tb_prime_sieve_ctrl;
    localparam int AW = 10;

    typedef struct {
        int id;
        int prime;
        bit wrap;
    } exp_t;

    logic          clk, rstn;
    logic          start [3];
    logic          req   [3];
    logic          busy  [3];
    logic          done  [3];
    logic          we    [3];
    logic          wdata [3];
    logic          ack   [3];
    logic          wrap  [3];
    logic [AW-1:0] waddr [3];
    logic [AW-1:0] raddr [3];
    logic [AW-1:0] prime [3];

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    for (genvar g = 0; g < 3; g++) begin : u
        logic mem [0:1023];
        logic rd;
        always @(posedge clk) begin
            if (we[g]) mem[waddr[g]] <= wdata[g];
            rd <= mem[raddr[g]];
        end
        prime_sieve_ctrl #(.N(g == 0 ? 30 : g == 1 ? 4 : 1000), .AW(AW)) dut (
            .clk(clk), .rstn(rstn), .start(start[g]), .busy(busy[g]), .done(done[g]),
            .ram_we(we[g]), .ram_waddr(waddr[g]), .ram_wdata(wdata[g]),
            .ram_raddr(raddr[g]), .ram_rdata(rd), .nxt_req(req[g]), .nxt_ack(ack[g]),
            .nxt_prime(prime[g]), .nxt_wrap(wrap[g])
        );
    end

    always #5 clk = ~clk;

    function automatic bit is_prime(input int n);
        if (n < 2) return 0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 0;
        return 1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int p, input bit w);
        exp_t e;
        e.id = id; e.prime = p; e.wrap = w;
        q.push_back(e);
    endtask

    task automatic zero_chk(input int g, input string name);
        chk(name, {busy[g], done[g], we[g], wdata[g], ack[g], wrap[g], waddr[g], raddr[g], prime[g]}, 0);
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (!done[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", longint'(done[g]), 1);
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic run_queries(input int g, input int k, input int budget);
        int n = 0;
        int c = 0;
        req[g] = 1'b1;
        while (c < k && n < budget) begin
            @(negedge clk);
            n++;
            if (ack[g]) c++;
        end
        req[g] = 1'b0;
        chk("ack_count", c, k);
    endtask

    // Ack monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (ack[g]) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ack: dut=%0d got prime=%0d wrap=%0d, required no ack", g, prime[g], wrap[g]);
                end else begin
                    e = q.pop_front();
                    if (e.id != g || int'(prime[g]) != e.prime || wrap[g] !== e.wrap) begin
                        fails++;
                        $display("FAIL ack_value: dut=%0d got prime=%0d wrap=%0d, required dut=%0d prime=%0d wrap=%0d",
                                 g, prime[g], wrap[g], e.id, e.prime, e.wrap);
                    end
                end
            end
        end
    end

    initial begin
        int n, tot, run, c;
        bit run_done, prev_busy;
        clk = 0;
        rstn = 0;
        for (int g = 0; g < 3; g++) begin
            start[g] = 0;
            req[g] = 0;
        end
        repeat (3) @(negedge clk);
        zero_chk(0, "reset_n30");
        zero_chk(1, "reset_n4");
        zero_chk(2, "reset_n1000");
        rstn = 1;
        @(negedge clk);

        // N=30 sieve, with a stray start while busy
        n = 0; tot = 0; run = 0; run_done = 0; prev_busy = 0;
        start[0] = 1;
        while (!done[0] && n < 400) begin
            @(negedge clk);
            n++;
            start[0] = (n == 40);
            if (we[0]) tot++;
            if (!run_done) begin
                if (we[0]) run++;
                else if (run > 0) run_done = 1;
            end
            if (done[0]) begin
                chk("busy_at_done", longint'(busy[0]), 0);
                chk("busy_before_done", longint'(prev_busy), 1);
            end
            prev_busy = busy[0];
        end
        start[0] = 0;
        chk("clear_run_len", run, 30);
        chk("we_total_n30", tot, 51);
        chk("done_n30", longint'(done[0]), 1);
        for (int k = 0; k < 30; k++) chk($sformatf("ram30[%0d]", k), longint'(u[0].mem[k]), longint'(is_prime(k)));

        // 11 back-to-back queries wrap back to 2
        for (int k = 2; k < 30; k++) if (is_prime(k)) push(0, k, 0);
        push(0, 2, 1);
        run_queries(0, 11, 2000);
        repeat (20) @(negedge clk);

        // walk cursor to 23, then time one query to 29
        for (int k = 3; k <= 23; k++) if (is_prime(k)) push(0, k, 0);
        run_queries(0, 8, 1000);
        push(0, 29, 0);
        req[0] = 1;
        @(negedge clk);
        n = 1;
        req[0] = 0;
        while (!ack[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("query_latency", n, 13);
        repeat (3) @(negedge clk);

        // start beats nxt_req in READY
        start[0] = 1;
        req[0] = 1;
        @(negedge clk);
        start[0] = 0;
        req[0] = 0;
        chk("restart_done_low", longint'(done[0]), 0);
        chk("restart_busy_high", longint'(busy[0]), 1);
        chk("restart_no_ack", longint'(ack[0]), 0);
        chk("restart_we", longint'(we[0]), 1);

        // N=4 boundary
        pulse_start(1);
        wait_done(1, 200);
        for (int k = 0; k < 4; k++) chk($sformatf("ram4[%0d]", k), longint'(u[1].mem[k]), longint'(is_prime(k)));
        push(1, 2, 0);
        push(1, 3, 0);
        push(1, 2, 1);
        run_queries(1, 3, 200);

        // N=1000: reset during i=3 marking, then full rerun
        pulse_start(2);
        n = 0;
        while (!(we[2] && !wdata[2] && waddr[2] == AW'(9)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("mark_i3_seen", longint'(n < 5000), 1);
        #2 rstn = 0;
        #1;
        chk("abort_we", longint'(we[2]), 0);
        zero_chk(2, "abort_outputs");
        @(negedge clk);
        rstn = 1;
        repeat (5) @(negedge clk);
        chk("abort_done_stays_low", longint'(done[2]), 0);
        pulse_start(2);
        wait_done(2, 20000);
        for (int k = 2; k < 1000; k++) if (is_prime(k)) push(2, k, 0);
        push(2, 2, 1);
        n = 0;
        c = 0;
        req[2] = 1;
        while (n < 20000) begin
            @(negedge clk);
            n++;
            if (ack[2]) begin
                if (wrap[2]) break;
                c++;
            end
        end
        req[2] = 0;
        chk("primes_before_wrap", c, 168);
        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
